// File: rtl/dm_arb_pkg.sv
// Shared constants for the data-memory arbiter: memory op codes, owner encoding, lock defaults.
package dm_arb_pkg;

  localparam int unsigned DmDw  = 32;
  localparam int unsigned DmOpw = 3;

  // Memory access op codes
  localparam logic [2:0] OpWd  = 3'd0;
  localparam logic [2:0] OpHf  = 3'd1;
  localparam logic [2:0] OpBt  = 3'd2;
  localparam logic [2:0] OpUhf = 3'd3;
  localparam logic [2:0] OpUbt = 3'd4;

  // Requester (owner) encoding
  localparam logic ArbM0 = 1'b0;
  localparam logic ArbM1 = 1'b1;

  localparam int unsigned LockMaxDef = 4;

endpackage

// File: rtl/dm_arb_if.sv
// One requester's handshake into dm_arb: master = requester side, slave = arbiter side.
interface dm_arb_if
  import dm_arb_pkg::*;
#(
  parameter int unsigned DW  = DmDw,
  parameter int unsigned OPW = DmOpw
) ();

  logic           req;
  logic           we;
  logic [OPW-1:0] op;
  logic [DW-1:0]  addr;
  logic [DW-1:0]  wdata;
  logic [DW-1:0]  pc;
  logic           lock;
  logic           gnt;
  logic           rvalid;
  logic [DW-1:0]  rdata;

  modport master (
    output req, we, op, addr, wdata, pc, lock,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, op, addr, wdata, pc, lock,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/dm_arb_rr_pick.sv
// Two-way round-robin selector. With DM_ARB_LOCK_EN defined, a locking owner keeps priority
// until LOCK_MAX consecutive locked grants, after which a waiting peer is forced in once.
module dm_arb_rr_pick
  import dm_arb_pkg::*;
#(
  parameter int unsigned LOCK_MAX = LockMaxDef
) (
  input  logic [1:0] req_i,
  input  logic [1:0] lock_i,
  input  logic       ptr_i,
  input  logic       owner_i,
  input  logic [2:0] lock_cnt_i,
  output logic [1:0] gnt_o,
  output logic       win_o
);

  logic rr_win;

  assign rr_win = (&req_i) ? ptr_i : req_i[1];

`ifdef DM_ARB_LOCK_EN
  localparam logic [2:0] LockMax = 3'(LOCK_MAX);

  logic force_other;
  logic hold_owner;

  always_comb begin
    force_other = (lock_cnt_i >= LockMax) && req_i[~owner_i];
    hold_owner  = req_i[owner_i] && lock_i[owner_i] && !force_other;
    if (force_other) begin
      win_o = ~owner_i;
    end else if (hold_owner) begin
      win_o = owner_i;
    end else begin
      win_o = rr_win;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^{lock_i, owner_i, lock_cnt_i};
  assign win_o       = rr_win;
`endif

  always_comb begin
    gnt_o = 2'b00;
    if (|req_i) gnt_o[win_o] = 1'b1;
  end

endmodule

// File: rtl/dm_arb.sv
// Two-port data-memory arbiter: accept stage (combinational grant), access stage (stage-B regs),
// registered read return. Optional ownership locking under DM_ARB_LOCK_EN.
module dm_arb
  import dm_arb_pkg::*;
#(
  parameter int unsigned DW       = DmDw,
  parameter int unsigned OPW      = DmOpw,
  parameter int unsigned LOCK_MAX = LockMaxDef
) (
  input  logic           clk,
  input  logic           rst,
  dm_arb_if.slave        m0,
  dm_arb_if.slave        m1,
  output logic [DW-1:0]  dm_ax,
  output logic [DW-1:0]  dm_x,
  output logic [OPW-1:0] dm_op,
  output logic [DW-1:0]  dm_pcw,
  output logic           dm_en,
  input  logic [DW-1:0]  dm_z
);

  logic [1:0] req, lock, pick_gnt;
  logic       win, any_gnt;
  logic [2:0] lock_cnt;

  logic           b_valid_q, b_valid_d;
  logic           b_we_q, b_we_d;
  logic [OPW-1:0] b_op_q, b_op_d;
  logic [DW-1:0]  b_addr_q, b_addr_d;
  logic [DW-1:0]  b_wdata_q, b_wdata_d;
  logic [DW-1:0]  b_pc_q, b_pc_d;
  logic           b_owner_q, b_owner_d;
  logic           ptr_q, ptr_d;
  logic [1:0]     rvalid_q, rvalid_d;
  logic [DW-1:0]  rdata0_q, rdata0_d;
  logic [DW-1:0]  rdata1_q, rdata1_d;

  assign req = {m1.req, m0.req};
  assign lock = {m1.lock, m0.lock};

  dm_arb_rr_pick #(
    .LOCK_MAX(LOCK_MAX)
  ) u_rr_pick (
    .req_i     (req),
    .lock_i    (lock),
    .ptr_i     (ptr_q),
    .owner_i   (b_owner_q),
    .lock_cnt_i(lock_cnt),
    .gnt_o     (pick_gnt),
    .win_o     (win)
  );

  assign any_gnt = |pick_gnt;
  assign m0.gnt  = pick_gnt[0] & rst;
  assign m1.gnt  = pick_gnt[1] & rst;

  assign m0.rvalid = rvalid_q[0];
  assign m1.rvalid = rvalid_q[1];
  assign m0.rdata  = rdata0_q;
  assign m1.rdata  = rdata1_q;

  always_comb begin
    b_valid_d = any_gnt;
    b_we_d    = b_we_q;
    b_op_d    = b_op_q;
    b_addr_d  = b_addr_q;
    b_wdata_d = b_wdata_q;
    b_pc_d    = b_pc_q;
    b_owner_d = b_owner_q;
    ptr_d     = ptr_q;
    if (any_gnt) begin
      b_we_d    = win ? m1.we : m0.we;
      b_op_d    = win ? m1.op : m0.op;
      b_addr_d  = win ? m1.addr : m0.addr;
      b_wdata_d = win ? m1.wdata : m0.wdata;
      b_pc_d    = win ? m1.pc : m0.pc;
      b_owner_d = win;
      ptr_d     = ~win;
    end

    rvalid_d = 2'b00;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    if (b_valid_q && !b_we_q) begin
      if (b_owner_q == ArbM1) begin
        rvalid_d[1] = 1'b1;
        rdata1_d    = dm_z;
      end else begin
        rvalid_d[0] = 1'b1;
        rdata0_d    = dm_z;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      b_valid_q <= 1'b0;
      b_we_q    <= 1'b0;
      b_op_q    <= OPW'(OpWd);
      b_addr_q  <= '0;
      b_wdata_q <= '0;
      b_pc_q    <= '0;
      b_owner_q <= ArbM0;
      ptr_q     <= ArbM0;
      rvalid_q  <= 2'b00;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      b_valid_q <= b_valid_d;
      b_we_q    <= b_we_d;
      b_op_q    <= b_op_d;
      b_addr_q  <= b_addr_d;
      b_wdata_q <= b_wdata_d;
      b_pc_q    <= b_pc_d;
      b_owner_q <= b_owner_d;
      ptr_q     <= ptr_d;
      rvalid_q  <= rvalid_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

`ifdef DM_ARB_LOCK_EN
  localparam logic [2:0] LockMax = 3'(LOCK_MAX);

  logic [2:0] lock_cnt_q, lock_cnt_d;

  // Counts consecutive locked grants to the same owner; a non-locked grant or owner change restarts it
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (any_gnt) begin
      if (!lock[win]) begin
        lock_cnt_d = 3'd0;
      end else if (win != b_owner_q) begin
        lock_cnt_d = 3'd1;
      end else if (lock_cnt_q < LockMax) begin
        lock_cnt_d = lock_cnt_q + 3'd1;
      end
    end else if (!lock[b_owner_q]) begin
      lock_cnt_d = 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) lock_cnt_q <= 3'd0;
    else      lock_cnt_q <= lock_cnt_d;
  end

  assign lock_cnt = lock_cnt_q;
`else
  assign lock_cnt = 3'd0;
`endif

  // Memory side is forced quiet while reset is held so a latched store never commits
  always_comb begin
    dm_en  = rst & b_valid_q & b_we_q;
    dm_ax  = rst ? b_addr_q : '0;
    dm_x   = rst ? b_wdata_q : '0;
    dm_pcw = rst ? b_pc_q : '0;
    dm_op  = (rst && b_valid_q) ? b_op_q : OPW'(OpWd);
  end

endmodule

// File: tb/tb_dm_arb.sv
// Directed testbench for dm_arb with a small byte-addressed memory model.
// The lock-priority scenario is compiled in only when DM_ARB_LOCK_EN is defined.
module tb_dm_arb;
  import dm_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] dm_ax, dm_x, dm_pcw, dm_z;
  logic [2:0]  dm_op;
  logic        dm_en;

  logic [31:0] mem [0:63];
  logic        bd_we = 1'b0;
  logic [5:0]  bd_idx = '0;
  logic [31:0] bd_data = '0;
  logic [31:0] rd_word, rd_sh;

  int n_checks = 0;
  int n_errors = 0;

  dm_arb_if m0_if ();
  dm_arb_if m1_if ();

  dm_arb u_dut (
    .clk   (clk),
    .rst   (rst),
    .m0    (m0_if),
    .m1    (m1_if),
    .dm_ax (dm_ax),
    .dm_x  (dm_x),
    .dm_op (dm_op),
    .dm_pcw(dm_pcw),
    .dm_en (dm_en),
    .dm_z  (dm_z)
  );

  always #5 clk = ~clk;

  always_comb begin
    rd_word = mem[dm_ax[7:2]];
    rd_sh   = rd_word >> {dm_ax[1:0], 3'b000};
    case (dm_op)
      OpBt:    dm_z = {{24{rd_sh[7]}}, rd_sh[7:0]};
      OpUbt:   dm_z = {24'h0, rd_sh[7:0]};
      OpHf:    dm_z = {{16{rd_sh[15]}}, rd_sh[15:0]};
      OpUhf:   dm_z = {16'h0, rd_sh[15:0]};
      default: dm_z = rd_word;
    endcase
  end

  always @(posedge clk) begin
    if (dm_en) begin
      case (dm_op)
        OpBt:    mem[dm_ax[7:2]][{dm_ax[1:0], 3'b000} +: 8] <= dm_x[7:0];
        OpHf:    mem[dm_ax[7:2]][{dm_ax[1], 4'b0000} +: 16] <= dm_x[15:0];
        default: mem[dm_ax[7:2]] <= dm_x;
      endcase
    end else if (bd_we) begin
      mem[bd_idx] <= bd_data;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic drive(input int p, input logic req, input logic we, input logic [2:0] op,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (p == 0) begin
      m0_if.req = req; m0_if.we = we; m0_if.op = op; m0_if.addr = addr; m0_if.wdata = wdata;
    end else begin
      m1_if.req = req; m1_if.we = we; m1_if.op = op; m1_if.addr = addr; m1_if.wdata = wdata;
    end
  endtask

  task automatic idle_both();
    drive(0, 1'b0, 1'b0, OpWd, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, OpWd, 32'h0, 32'h0);
  endtask

  task automatic poke(input logic [5:0] idx, input logic [31:0] data);
    bd_we = 1'b1; bd_idx = idx; bd_data = data;
    step();
    bd_we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  initial begin
    m0_if.pc = 32'h0000_0100; m0_if.lock = 1'b0;
    m1_if.pc = 32'h0000_0200; m1_if.lock = 1'b0;
    idle_both();
    #1;

    // Reset state
    step();
    samp();
    check_eq("rst_dm_en", dm_en, 1'b0);
    check_eq("rst_dm_ax", dm_ax, 32'h0);
    check_eq("rst_dm_op", dm_op, OpWd);
    check_eq("rst_rvalid", {m1_if.rvalid, m0_if.rvalid}, 2'b00);
    check_eq("rst_rdata0", m0_if.rdata, 32'h0);
    step();
    rst = 1'b1;

    // Single m0 load: gnt in cycle 0, access in 1, rvalid in 2
    poke(6'd4, 32'hDEAD_BEEF);
    drive(0, 1'b1, 1'b0, OpWd, 32'h10, 32'h0);
    samp();
    check_eq("ld_m0_gnt", m0_if.gnt, 1'b1);
    check_eq("ld_m1_gnt", m1_if.gnt, 1'b0);
    step();
    drive(0, 1'b0, 1'b0, OpWd, 32'h0, 32'h0);
    samp();
    check_eq("ld_dm_ax", dm_ax, 32'h10);
    check_eq("ld_dm_en", dm_en, 1'b0);
    check_eq("ld_dm_pcw", dm_pcw, 32'h100);
    check_eq("ld_rvalid_early", m0_if.rvalid, 1'b0);
    step();
    samp();
    check_eq("ld_rvalid", m0_if.rvalid, 1'b1);
    check_eq("ld_rdata", m0_if.rdata, 32'hDEAD_BEEF);
    step();
    samp();
    check_eq("ld_rvalid_drop", m0_if.rvalid, 1'b0);
    check_eq("ld_rdata_hold", m0_if.rdata, 32'hDEAD_BEEF);
    check_eq("idle_dm_ax_hold", dm_ax, 32'h10);

    // Both requesting: m0 store / m1 load, grants alternate from m0
    do_reset();
    drive(0, 1'b1, 1'b1, OpWd, 32'h30, 32'hA5A5_A5A5);
    drive(1, 1'b1, 1'b0, OpWd, 32'h10, 32'h0);
    for (int k = 0; k < 6; k++) begin
      samp();
      check_eq($sformatf("rr_m0_gnt%0d", k), m0_if.gnt, (k % 2) == 0);
      check_eq($sformatf("rr_m1_gnt%0d", k), m1_if.gnt, (k % 2) == 1);
      check_eq($sformatf("rr_dm_en%0d", k), dm_en, (k > 0) && (((k - 1) % 2) == 0));
      step();
    end
    idle_both();
    step();
    step();
    step();
    check_eq("rr_mem_store", mem[12], 32'hA5A5_A5A5);

    // m1 word store then m0 signed byte load from the same word
    drive(1, 1'b1, 1'b1, OpWd, 32'h20, 32'h1234_5678);
    samp();
    check_eq("raw_m1_gnt", m1_if.gnt, 1'b1);
    step();
    drive(1, 1'b0, 1'b0, OpWd, 32'h0, 32'h0);
    drive(0, 1'b1, 1'b0, OpBt, 32'h21, 32'h0);
    samp();
    check_eq("raw_m0_gnt", m0_if.gnt, 1'b1);
    check_eq("raw_st_en", dm_en, 1'b1);
    check_eq("raw_st_ax", dm_ax, 32'h20);
    step();
    idle_both();
    samp();
    check_eq("raw_ld_ax", dm_ax, 32'h21);
    check_eq("raw_ld_op", dm_op, OpBt);
    step();
    samp();
    check_eq("raw_rvalid", m0_if.rvalid, 1'b1);
    check_eq("raw_rdata", m0_if.rdata, 32'h0000_0056);
    check_eq("raw_m1_rvalid", m1_if.rvalid, 1'b0);
    check_eq("raw_mem", mem[8], 32'h1234_5678);
    step();

    // Reset during the access cycle of an m0 store
    poke(6'd16, 32'h0);
    drive(0, 1'b1, 1'b1, OpWd, 32'h40, 32'hCAFE_F00D);
    samp();
    check_eq("rmid_m0_gnt", m0_if.gnt, 1'b1);
    step();
    rst = 1'b0;
    idle_both();
    samp();
    check_eq("rmid_dm_en", dm_en, 1'b0);
    step();
    rst = 1'b1;
    samp();
    check_eq("rmid_mem", mem[16], 32'h0);
    check_eq("rmid_rvalid", {m1_if.rvalid, m0_if.rvalid}, 2'b00);
    check_eq("rmid_dm_en_after", dm_en, 1'b0);
    step();
    drive(0, 1'b1, 1'b0, OpWd, 32'h10, 32'h0);
    drive(1, 1'b1, 1'b0, OpWd, 32'h10, 32'h0);
    samp();
    check_eq("rmid_ptr_m0", m0_if.gnt, 1'b1);
    check_eq("rmid_ptr_m1", m1_if.gnt, 1'b0);
    step();
    idle_both();
    step();
    step();
    step();

    // m0 pulses req while m1 holds round-robin priority
    poke(6'd18, 32'h0);
    drive(0, 1'b1, 1'b1, OpWd, 32'h44, 32'h1);
    step();
    drive(0, 1'b1, 1'b1, OpWd, 32'h48, 32'h2);
    drive(1, 1'b1, 1'b1, OpWd, 32'h4C, 32'h3);
    samp();
    check_eq("pulse_m0_gnt", m0_if.gnt, 1'b0);
    check_eq("pulse_m1_gnt", m1_if.gnt, 1'b1);
    step();
    idle_both();
    samp();
    check_eq("pulse_dm_ax", dm_ax, 32'h4C);
    check_eq("pulse_dm_en", dm_en, 1'b1);
    step();
    samp();
    check_eq("pulse_m0_rvalid", m0_if.rvalid, 1'b0);
    step();
    samp();
    check_eq("pulse_m0_rvalid2", m0_if.rvalid, 1'b0);
    check_eq("pulse_mem", mem[18], 32'h0);

`ifdef DM_ARB_LOCK_EN
    // Locked m0 wins LOCK_MAX grants, m1 forced in once, m0 resumes
    do_reset();
    m0_if.lock = 1'b1;
    drive(0, 1'b1, 1'b1, OpWd, 32'h50, 32'h5);
    drive(1, 1'b1, 1'b1, OpWd, 32'h54, 32'h6);
    for (int k = 0; k < 7; k++) begin
      samp();
      check_eq($sformatf("lock_m0_gnt%0d", k), m0_if.gnt, k != 4);
      check_eq($sformatf("lock_m1_gnt%0d", k), m1_if.gnt, k == 4);
      step();
    end
    idle_both();
    m0_if.lock = 1'b0;
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
